lbp_win_sched: RTL and testbench

LBP_WIN_SCHED -- requirements
Module: lbp_win_sched

---
 rtl/lbp_pkg.sv | 34 +++
 rtl/lbp_win_buf.sv | 66 ++++++
 rtl/lbp_win_sched.sv | 184 ++++++++++++++++++
 tb/tb_lbp_win_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared parameter defaults, FSM encoding and fill-order helper for the LBP window scheduler.
package lbp_pkg;

  localparam int IMG_W_DEF  = 128;
  localparam int ADDR_W_DEF = 14;
  localparam int PIX_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_EMIT = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Fill read k (0..8) -> {col, row}: left column first, top row first within a column.
  function automatic logic [3:0] fill_rc(input logic [3:0] k);
    logic [3:0] rc;
    case (k)
      4'd0:    rc = {2'd0, 2'd0};
      4'd1:    rc = {2'd0, 2'd1};
      4'd2:    rc = {2'd0, 2'd2};
      4'd3:    rc = {2'd1, 2'd0};
      4'd4:    rc = {2'd1, 2'd1};
      4'd5:    rc = {2'd1, 2'd2};
      4'd6:    rc = {2'd2, 2'd0};
      4'd7:    rc = {2'd2, 2'd1};
      4'd8:    rc = {2'd2, 2'd2};
      default: rc = 4'd0;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/lbp_win_buf.sv
// 3x3 pixel window register: single-pixel column loads and a one-column left shift.
module lbp_win_buf
  import lbp_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift,
  input  logic               wr_en,
  input  logic [1:0]         wr_row,
  input  logic [1:0]         wr_col,
  input  logic [PIX_W-1:0]   wr_data,
  output logic [9*PIX_W-1:0] win_pix
);

  logic [PIX_W-1:0] pix_q [9];
  logic [PIX_W-1:0] pix_d [9];
  logic [3:0]       wr_idx;

  assign wr_idx = ({2'd0, wr_row} * 4'd3) + {2'd0, wr_col};

  // Shift moves columns 1,2 into 0,1; column 2 is then refilled by the column loads.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      pix_d[i] = pix_q[i];
    end
    if (shift) begin
      for (int r = 0; r < 3; r++) begin
        pix_d[3*r]     = pix_q[3*r + 1];
        pix_d[3*r + 1] = pix_q[3*r + 2];
      end
    end else if (wr_en) begin
      for (int i = 0; i < 9; i++) begin
        if (wr_idx == 4'(i)) begin
          pix_d[i] = wr_data;
        end else begin
          pix_d[i] = pix_q[i];
        end
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        pix_d[i] = pix_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        pix_q[i] <= {PIX_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        pix_q[i] <= pix_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      win_pix[i*PIX_W +: PIX_W] = pix_q[i];
    end
  end

endmodule

// File: rtl/lbp_win_sched.sv
// Raster scheduler: reads gray pixels, assembles 3x3 windows around interior centres
// and hands them to the LBP core with a valid/ready handshake.
module lbp_win_sched
  import lbp_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gray_ready,
  output logic               gray_req,
  output logic [ADDR_W-1:0]  gray_addr,
  input  logic [PIX_W-1:0]   gray_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [ADDR_W-1:0]  win_addr,
  output logic [9*PIX_W-1:0] win_pix,
  output logic               done
);

  localparam int            CW    = $clog2(IMG_W);
  localparam logic [CW-1:0] FIRST = CW'(1);
  localparam logic [CW-1:0] LAST  = CW'(IMG_W - 2);

  state_t            state_q, state_d;
  logic [CW-1:0]     row_q, row_d, col_q, col_d;
  logic [3:0]        iss_q, iss_d, cap_q, cap_d;
  logic              gray_req_q, gray_req_d;
  logic [ADDR_W-1:0] gray_addr_q, gray_addr_d;
  logic [ADDR_W-1:0] win_addr_q, win_addr_d;
  logic              win_valid_q, win_valid_d;
  logic              done_q, done_d;
  logic              xfer, is_fill, is_read, last_cap, buf_shift, buf_wr;
  logic [3:0]        n_reads, iss_rc, cap_rc;

  assign xfer      = win_valid_q & win_ready;
  assign is_fill   = (state_q == ST_FILL);
  assign is_read   = (state_q == ST_FILL) || (state_q == ST_STEP);
  assign n_reads   = is_fill ? 4'd9 : 4'd3;
  // STEP only ever touches the right-hand column of the window.
  assign iss_rc    = is_fill ? fill_rc(iss_q) : {2'd2, iss_q[1:0]};
  assign cap_rc    = is_fill ? fill_rc(cap_q) : {2'd2, cap_q[1:0]};
  assign last_cap  = is_read && gray_req_q && (cap_q == (n_reads - 4'd1));
  assign buf_wr    = is_read && gray_req_q;
  assign buf_shift = (state_q == ST_EMIT) && xfer && (col_q != LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gray_ready) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL, ST_STEP: begin
        if (last_cap) begin
          state_d = ST_EMIT;
        end else begin
          state_d = state_q;
        end
      end
      ST_EMIT: begin
        if (!xfer) begin
          state_d = ST_EMIT;
        end else if (col_q != LAST) begin
          state_d = ST_STEP;
        end else if (row_q != LAST) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    iss_d       = iss_q;
    cap_d       = cap_q;
    gray_req_d  = 1'b0;
    gray_addr_d = gray_addr_q;
    win_addr_d  = win_addr_q;
    win_valid_d = 1'b0;
    done_d      = done_q;
    case (state_q)
      ST_FILL, ST_STEP: begin
        if (gray_ready && (iss_q < n_reads)) begin
          gray_req_d  = 1'b1;
          gray_addr_d = {row_q - FIRST + CW'(iss_rc[1:0]), col_q - FIRST + CW'(iss_rc[3:2])};
          iss_d       = iss_q + 4'd1;
        end else begin
          gray_req_d  = 1'b0;
        end
        if (gray_req_q) begin
          cap_d = cap_q + 4'd1;
        end else begin
          cap_d = cap_q;
        end
        if (last_cap) begin
          win_addr_d = {row_q, col_q};
        end else begin
          win_addr_d = win_addr_q;
        end
      end
      ST_EMIT: begin
        // Valid rises one cycle after the final capture and drops on the transfer edge.
        win_valid_d = !xfer;
        if (xfer) begin
          iss_d = 4'd0;
          cap_d = 4'd0;
          if (col_q != LAST) begin
            col_d = col_q + FIRST;
          end else if (row_q != LAST) begin
            col_d = FIRST;
            row_d = row_q + FIRST;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          iss_d = iss_q;
        end
      end
      ST_DONE: done_d = 1'b1;
      default: done_d = done_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q       <= FIRST;
      col_q       <= FIRST;
      iss_q       <= 4'd0;
      cap_q       <= 4'd0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= {ADDR_W{1'b0}};
      win_addr_q  <= {ADDR_W{1'b0}};
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      iss_q       <= iss_d;
      cap_q       <= cap_d;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      win_addr_q  <= win_addr_d;
      win_valid_q <= win_valid_d;
      done_q      <= done_d;
    end
  end

  lbp_win_buf #(.PIX_W(PIX_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .shift   (buf_shift),
    .wr_en   (buf_wr),
    .wr_row  (cap_rc[1:0]),
    .wr_col  (cap_rc[3:2]),
    .wr_data (gray_data),
    .win_pix (win_pix)
  );

  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;
  assign win_valid = win_valid_q;
  assign win_addr  = win_addr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lbp_win_sched.sv
// Self-checking bench for lbp_win_sched on a 32x32 image: ramp and random images,
// back-pressure, gray_ready drops and a mid-scan reset against a software window model.
module tb_lbp_win_sched;

  localparam int N    = 32;
  localparam int AW   = 10;
  localparam int PW   = 8;
  localparam int NW   = (N - 2) * (N - 2);
  localparam int NREQ = (N - 2) * (9 + 3 * (N - 3));
  localparam int LAST_ADDR = (N - 2) * N + (N - 2);

  logic            clk;
  logic            reset;
  logic            gray_ready;
  logic            gray_req;
  logic [AW-1:0]   gray_addr;
  logic [PW-1:0]   gray_data;
  logic            win_valid;
  logic            win_ready;
  logic [AW-1:0]   win_addr;
  logic [9*PW-1:0] win_pix;
  logic            done;

  logic [PW-1:0] img [N*N];
  logic [PW-1:0] junk;

  int n_assert, n_fail;
  int exp_idx, rd_k, req_cnt, last_addr, mode;
  int stall_cnt, drop_cnt, drop_wait;
  bit drop_done, prev_hold, seen_done, done_chk;

  lbp_win_sched #(.IMG_W(N), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_addr   (win_addr),
    .win_pix    (win_pix),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the addressed pixel only while a request is outstanding.
  assign gray_data = gray_req ? img[gray_addr] : junk;

  function automatic int win_row(input int i);
    return 1 + i / (N - 2);
  endfunction

  function automatic int win_col(input int i);
    return 1 + i % (N - 2);
  endfunction

  function automatic logic [AW-1:0] centre_addr(input int i);
    return AW'(win_row(i) * N + win_col(i));
  endfunction

  function automatic logic [9*PW-1:0] golden_pix(input int i);
    logic [9*PW-1:0] w;
    for (int k = 0; k < 9; k++) begin
      w[k*PW +: PW] = img[(win_row(i) - 1 + k / 3) * N + (win_col(i) - 1 + k % 3)];
    end
    return w;
  endfunction

  function automatic logic [9*PW-1:0] ramp_first_pix();
    logic [9*PW-1:0] w;
    for (int k = 0; k < 9; k++) begin
      w[k*PW +: PW] = PW'(((k / 3) * N + (k % 3)) % 256);
    end
    return w;
  endfunction

  function automatic int reads_for(input int i);
    if (i >= NW) return 0;
    return (win_col(i) == 1) ? 9 : 3;
  endfunction

  function automatic logic [AW-1:0] read_addr(input int i, input int k);
    int rr, cc;
    if (win_col(i) == 1) begin
      rr = win_row(i) - 1 + k % 3;
      cc = win_col(i) - 1 + k / 3;
    end else begin
      rr = win_row(i) - 1 + k;
      cc = win_col(i) + 1;
    end
    return AW'(rr * N + cc);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_gray_req", gray_req, 0);
    chk("rst_gray_addr", gray_addr, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_addr", win_addr, 0);
    chk("rst_win_pix", win_pix, 0);
    chk("rst_done", done, 0);
  endtask

  task automatic reset_model();
    exp_idx = 0; rd_k = 0; req_cnt = 0; last_addr = -1;
    stall_cnt = 0; drop_cnt = 0; drop_wait = 0;
    drop_done = 0; prev_hold = 0; seen_done = 0; done_chk = 0;
  endtask

  task automatic policy();
    junk = PW'($urandom);
    case (mode)
      0: begin
        if (win_valid && exp_idx == 4 && stall_cnt < 5) begin
          win_ready = 1'b0;
          stall_cnt++;
        end else begin
          win_ready = 1'b1;
        end
        if (drop_cnt > 0) begin
          gray_ready = 1'b0;
          drop_cnt--;
        end else if (!drop_done && gray_req && exp_idx == 3 && rd_k == 1) begin
          gray_ready = 1'b0;
          drop_cnt = 2;
          drop_done = 1;
          drop_wait = 2;
        end else begin
          gray_ready = 1'b1;
        end
      end
      2: begin
        win_ready  = ($urandom_range(0, 3) != 0);
        gray_ready = ($urandom_range(0, 4) != 0);
      end
      default: begin
        win_ready  = 1'b1;
        gray_ready = 1'b1;
      end
    endcase
  endtask

  task automatic monitor();
    if (done_chk) begin
      done_chk = 0;
      chk("done_after_last", done, 1);
      chk("done_gray_req", gray_req, 0);
      chk("done_win_valid", win_valid, 0);
    end
    if (drop_wait > 0) begin
      drop_wait--;
      if (drop_wait == 0) chk("req_after_drop", gray_req, 0);
    end
    if (prev_hold) begin
      chk("hold_valid", win_valid, 1);
      chk("hold_addr", win_addr, centre_addr(exp_idx));
      chk("hold_pix", win_pix, golden_pix(exp_idx));
      chk("hold_no_req", gray_req, 0);
    end
    if (gray_req) begin
      req_cnt++;
      n_assert++;
      assert (rd_k < reads_for(exp_idx)) else begin
        n_fail++;
        $error("FAIL read_budget: read %0d of window %0d, allowed %0d", rd_k + 1, exp_idx, reads_for(exp_idx));
      end
      if (rd_k < reads_for(exp_idx)) chk("read_addr", gray_addr, read_addr(exp_idx, rd_k));
      rd_k++;
    end
    if (win_valid && win_ready) begin
      n_assert++;
      assert (exp_idx < NW) else begin
        n_fail++;
        $error("FAIL extra_window: window %0d at addr %0h, expected only %0d", exp_idx, win_addr, NW);
      end
      if (exp_idx < NW) begin
        chk("win_addr", win_addr, centre_addr(exp_idx));
        chk("win_pix", win_pix, golden_pix(exp_idx));
        chk("done_early", done, 0);
      end
      if (mode == 0 && exp_idx == 0) begin
        chk("first_addr", win_addr, N + 1);
        chk("first_pix", win_pix, ramp_first_pix());
      end
      last_addr = int'(win_addr);
      exp_idx++;
      rd_k = 0;
      if (exp_idx == NW) done_chk = 1;
    end
    prev_hold = win_valid && !win_ready;
    if (done) seen_done = 1;
  endtask

  task automatic run_until(input int stop_idx, input int max_cyc);
    int cyc = 0;
    while (!seen_done && exp_idx < stop_idx && cyc < max_cyc) begin
      @(negedge clk);
      policy();
      monitor();
      cyc++;
    end
    n_assert++;
    assert (cyc < max_cyc) else begin
      n_fail++;
      $error("FAIL timeout: %0d cycles used, window %0d, budget %0d", cyc, exp_idx, max_cyc);
    end
  endtask

  task automatic end_checks();
    chk("win_count", exp_idx, NW);
    chk("req_count", req_cnt, NREQ);
    chk("last_addr", last_addr, LAST_ADDR);
    repeat (3) begin
      @(negedge clk);
      chk("done_sticky", done, 1);
      chk("done_no_req", gray_req, 0);
      chk("done_no_valid", win_valid, 0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    gray_ready = 1'b0;
    win_ready = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    mode = 1;
    reset = 1'b1;
    gray_ready = 1'b0;
    win_ready = 1'b0;
    junk = '0;
    reset_model();
    for (int a = 0; a < N * N; a++) img[a] = PW'(a % 256);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_req", gray_req, 0);
      chk("idle_no_valid", win_valid, 0);
    end

    // Ramp image with a 5-cycle stall at (1,5) and a gray_ready drop inside column (1,4).
    mode = 0;
    reset_model();
    run_until(NW + 1, 30000);
    end_checks();

    // Random image, reset mid-scan at row N/2, then a complete rescan.
    pulse_reset();
    for (int a = 0; a < N * N; a++) img[a] = PW'($urandom);
    mode = 1;
    reset_model();
    run_until((N / 2 - 1) * (N - 2) + 2, 30000);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #2;
    reset = 1'b0;
    reset_model();
    run_until(NW + 1, 30000);
    end_checks();

    // Random image with random back-pressure and gray_ready gaps.
    pulse_reset();
    for (int a = 0; a < N * N; a++) img[a] = PW'($urandom);
    mode = 2;
    reset_model();
    run_until(NW + 1, 40000);
    end_checks();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
